pixel_stream_src: RTL and testbench

PIXEL_STREAM_SRC -- requirements
Module: pixel_stream_src

---
 rtl/pixel_stream_src.sv | 252 +++++++++++++++++++++++++
 tb/tb_pixel_stream_src.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_src.sv
// Raster-order pixel source.
// Reads a frame memory one pixel per cycle, inserts idle cycles between
// lines, and forwards each pixel with its coordinates and line/frame markers.
// Pixel pipeline: read strobe -> memory latency stage -> output register.
// A read issued in cycle k therefore appears on gray/gray_valid in cycle k+2.
module pixel_stream_src #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int HBLANK       = 4,
    localparam int ADDR_W = (IMAGE_WIDTH * IMAGE_HEIGHT > 1) ?
                            $clog2(IMAGE_WIDTH * IMAGE_HEIGHT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              gray_valid,
    output logic [7:0]        gray,
    output logic [31:0]       pix_row,
    output logic [31:0]       pix_col,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int HB_W  = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'((HBLANK > 0) ? (HBLANK - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_HBLANK = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Control state
    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   lin_q, lin_d;      // linear address of the next read
    logic [HB_W-1:0]     hb_q, hb_d;
    logic                drain_q, drain_d;
    logic                rd_d, sof_d, eol_d;

    // Issue stage (aligned with mem_rd_en)
    logic                rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ROW_W-1:0]    m0_row_q;
    logic [COL_W-1:0]    m0_col_q;
    logic                m0_sof_q, m0_eol_q;

    // Memory-latency stage (aligned with mem_rdata)
    logic                p1_valid_q;
    logic [ROW_W-1:0]    p1_row_q;
    logic [COL_W-1:0]    p1_col_q;
    logic                p1_sof_q, p1_eol_q;

    // Output stage
    logic                gv_q;
    logic [7:0]          gray_q;
    logic [31:0]         pix_row_q, pix_col_q;
    logic                sof_q, eol_q;
    logic                busy_q, done_q;

    // Next-state logic: raster counters, line blanking and pipeline drain.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        lin_d   = lin_q;
        hb_d    = hb_q;
        drain_d = drain_q;
        rd_d    = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    lin_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (!hold) begin
                    rd_d  = 1'b1;
                    sof_d = (row_q == '0) && (col_q == '0);
                    eol_d = (col_q == COL_LAST);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q != ROW_LAST) begin
                            row_d = row_q + ROW_W'(1);
                            lin_d = lin_q + ADDR_W'(1);
                            if (HBLANK > 0) begin
                                state_d = ST_HBLANK;
                                hb_d    = '0;
                            end else begin
                                state_d = ST_STREAM;
                            end
                        end else begin
                            // Last pixel of the frame: park counters at zero.
                            row_d   = '0;
                            lin_d   = '0;
                            state_d = ST_DRAIN;
                            drain_d = 1'b0;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                        lin_d = lin_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_HBLANK: begin
                // Blanking is a fixed length; hold has no effect here.
                if (hb_q == HB_LAST) begin
                    state_d = ST_STREAM;
                end else begin
                    hb_d = hb_q + HB_W'(1);
                end
            end
            ST_DRAIN: begin
                // Two cycles let the last read reach the output register.
                if (drain_q) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            lin_q   <= '0;
            hb_q    <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lin_q   <= lin_d;
            hb_q    <= hb_d;
            drain_q <= drain_d;
        end
    end

    // Issue stage: read strobe, address and the metadata of that pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= 1'b0;
            addr_q   <= '0;
            m0_row_q <= '0;
            m0_col_q <= '0;
            m0_sof_q <= 1'b0;
            m0_eol_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            m0_sof_q <= sof_d;
            m0_eol_q <= eol_d;
            if (rd_d) begin
                addr_q   <= lin_q;
                m0_row_q <= row_q;
                m0_col_q <= col_q;
            end
        end
    end

    // Latency stage: carries metadata while the memory returns the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid_q <= 1'b0;
            p1_row_q   <= '0;
            p1_col_q   <= '0;
            p1_sof_q   <= 1'b0;
            p1_eol_q   <= 1'b0;
        end else begin
            p1_valid_q <= rd_q;
            p1_sof_q   <= rd_q & m0_sof_q;
            p1_eol_q   <= rd_q & m0_eol_q;
            if (rd_q) begin
                p1_row_q <= m0_row_q;
                p1_col_q <= m0_col_q;
            end
        end
    end

    // Output stage: captures the returned pixel with its coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gv_q      <= 1'b0;
            gray_q    <= 8'h00;
            pix_row_q <= 32'd0;
            pix_col_q <= 32'd0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            gv_q  <= p1_valid_q;
            sof_q <= p1_valid_q & p1_sof_q;
            eol_q <= p1_valid_q & p1_eol_q;
            if (p1_valid_q) begin
                gray_q    <= mem_rdata;
                pix_row_q <= 32'(p1_row_q);
                pix_col_q <= 32'(p1_col_q);
            end
        end
    end

    // Status: busy follows the registered state one cycle later; done fires
    // on the first idle cycle after a frame, so a reset never produces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_q != ST_IDLE);
            done_q <= busy_q && (state_q == ST_IDLE);
        end
    end

    assign mem_rd_en  = rd_q;
    assign mem_addr   = addr_q;
    assign gray_valid = gv_q;
    assign gray       = gray_q;
    assign pix_row    = pix_row_q;
    assign pix_col    = pix_col_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pixel_stream_src.sv
// Directed bench for pixel_stream_src: 4x3 image with HBLANK=2 (dut a) and
// HBLANK=0 (dut b), both driven by the same start/hold/rst stimulus.
// "Cycle k" outputs are sampled 1 time unit after the k-th rising edge,
// where edge 0 is the one that samples the start pulse.
module tb_pixel_stream_src;

    logic clk = 1'b0;
    logic rst, start, hold;

    logic       rd_a, gv_a, sof_a, eol_a, busy_a, done_a;
    logic [3:0] addr_a;
    logic [7:0] rdata_a = 8'h00, gray_a;
    logic [31:0] row_a, col_a;

    logic       rd_b, gv_b, sof_b, eol_b, busy_b, done_b;
    logic [3:0] addr_b;
    logic [7:0] rdata_b = 8'h00, gray_b;
    logic [31:0] row_b, col_b;

    typedef struct packed {
        logic        rd;
        logic [3:0]  addr;
        logic        gv;
        logic [7:0]  gray;
        logic [31:0] row;
        logic [31:0] col;
        logic        sof;
        logic        eol;
        logic        busy;
        logic        done;
    } obs_t;

    obs_t tr_a [0:63];
    obs_t tr_b [0:63];

    int checks = 0;
    int errors = 0;

    pixel_stream_src #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .HBLANK(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .gray_valid(gv_a), .gray(gray_a), .pix_row(row_a), .pix_col(col_a),
        .sof(sof_a), .eol(eol_a), .busy(busy_a), .done(done_a)
    );

    pixel_stream_src #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .HBLANK(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .gray_valid(gv_b), .gray(gray_b), .pix_row(row_b), .pix_col(col_b),
        .sof(sof_b), .eol(eol_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Frame memories: data = address + 0x10, one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_a) rdata_a <= {4'h0, addr_a} + 8'h10;
        if (rd_b) rdata_b <= {4'h0, addr_b} + 8'h10;
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        @(posedge clk);
        #1;
        tr_a[k] = '{rd: rd_a, addr: addr_a, gv: gv_a, gray: gray_a, row: row_a, col: col_a,
                    sof: sof_a, eol: eol_a, busy: busy_a, done: done_a};
        tr_b[k] = '{rd: rd_b, addr: addr_b, gv: gv_b, gray: gray_b, row: row_b, col: col_b,
                    sof: sof_b, eol: eol_b, busy: busy_b, done: done_b};
    endtask

    // Drive n cycles; start pulses at s0..s3, hold over [hlo,hhi], rst over [rlo,rhi].
    task automatic run(input int n, input int s0, input int s1, input int s2, input int s3,
                       input int hlo, input int hhi, input int rlo, input int rhi);
        for (int k = 0; k < n; k++) begin
            start = (k == s0) || (k == s1) || (k == s2) || (k == s3);
            hold  = (k >= hlo) && (k <= hhi);
            rst   = (k >= rlo) && (k <= rhi);
            tick(k);
        end
        start = 1'b0;
        hold  = 1'b0;
        rst   = 1'b0;
    endtask

    function automatic bit rng(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    function automatic bit basic_rd(input int k);
        return rng(k, 1, 4) || rng(k, 7, 10) || rng(k, 13, 16);
    endfunction

    function automatic bit hold_rd(input int k);
        return (k == 1) || rng(k, 5, 7) || rng(k, 10, 13) || rng(k, 16, 19);
    endfunction

    task automatic chk_zero(input string tag, input int k, input bit use_b);
        obs_t o;
        o = use_b ? tr_b[k] : tr_a[k];
        chk({tag, "_rd"},   k, 32'(o.rd),   32'd0);
        chk({tag, "_addr"}, k, 32'(o.addr), 32'd0);
        chk({tag, "_gv"},   k, 32'(o.gv),   32'd0);
        chk({tag, "_gray"}, k, 32'(o.gray), 32'd0);
        chk({tag, "_row"},  k, o.row,       32'd0);
        chk({tag, "_col"},  k, o.col,       32'd0);
        chk({tag, "_sof"},  k, 32'(o.sof),  32'd0);
        chk({tag, "_eol"},  k, 32'(o.eol),  32'd0);
        chk({tag, "_busy"}, k, 32'(o.busy), 32'd0);
        chk({tag, "_done"}, k, 32'(o.done), 32'd0);
    endtask

    // Walk a trace: read addresses must count 0..11, pixels appear in
    // raster order with data addr+0x10, and markers only with gray_valid.
    task automatic chk_pixels(input string tag, input int n, input bit use_b);
        obs_t o;
        int p = 0;
        int a = 0;
        for (int k = 0; k < n; k++) begin
            o = use_b ? tr_b[k] : tr_a[k];
            if (o.rd) begin
                chk({tag, "_addr"}, k, 32'(o.addr), 32'(a));
                a++;
            end
            if (o.gv) begin
                chk({tag, "_gray"}, k, 32'(o.gray), 32'(16 + p));
                chk({tag, "_row"},  k, o.row,       32'(p / 4));
                chk({tag, "_col"},  k, o.col,       32'(p % 4));
                chk({tag, "_sof"},  k, 32'(o.sof),  32'(p == 0));
                chk({tag, "_eol"},  k, 32'(o.eol),  32'((p % 4) == 3));
                p++;
            end else begin
                chk({tag, "_sof_idle"}, k, 32'(o.sof), 32'd0);
                chk({tag, "_eol_idle"}, k, 32'(o.eol), 32'd0);
            end
        end
        chk({tag, "_reads"},  n, 32'(a), 32'd12);
        chk({tag, "_pixels"}, n, 32'(p), 32'd12);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;

        // Reset state
        tick(0);
        chk_zero("rst_a", 0, 1'b0);
        chk_zero("rst_b", 0, 1'b1);
        rst = 1'b0;
        tick(0);

        // Basic frame
        run(24, 0, -1, -1, -1, -1, -1, -1, -1);
        for (int k = 0; k < 24; k++) begin
            chk("basic_rd",   k, 32'(tr_a[k].rd),   32'(basic_rd(k)));
            chk("basic_gv",   k, 32'(tr_a[k].gv),   32'(basic_rd(k - 2)));
            chk("basic_busy", k, 32'(tr_a[k].busy), 32'(rng(k, 1, 18)));
            chk("basic_done", k, 32'(tr_a[k].done), 32'(k == 19));
            chk("hb0_rd",     k, 32'(tr_b[k].rd),   32'(rng(k, 1, 12)));
            chk("hb0_gv",     k, 32'(tr_b[k].gv),   32'(rng(k, 3, 14)));
            chk("hb0_busy",   k, 32'(tr_b[k].busy), 32'(rng(k, 1, 14)));
            chk("hb0_done",   k, 32'(tr_b[k].done), 32'(k == 15));
        end
        chk_pixels("basic_px", 24, 1'b0);
        chk_pixels("hb0_px", 24, 1'b1);

        // Hold during cycles 2-4
        run(26, 0, -1, -1, -1, 2, 4, -1, -1);
        for (int k = 0; k < 26; k++) begin
            chk("hold_rd",   k, 32'(tr_a[k].rd),   32'(hold_rd(k)));
            chk("hold_gv",   k, 32'(tr_a[k].gv),   32'(hold_rd(k - 2)));
            chk("hold_busy", k, 32'(tr_a[k].busy), 32'(rng(k, 1, 21)));
            chk("hold_done", k, 32'(tr_a[k].done), 32'(k == 22));
        end
        chk("hold_addr1", 1, 32'(tr_a[1].addr), 32'd0);
        chk("hold_addr5", 5, 32'(tr_a[5].addr), 32'd1);
        chk_pixels("hold_px", 26, 1'b0);

        // Start while busy (5, 18 ignored) and in the done cycle (19 accepted)
        run(42, 0, 5, 18, 19, -1, -1, -1, -1);
        for (int k = 0; k < 42; k++) begin
            chk("restart_rd",   k, 32'(tr_a[k].rd),   32'(basic_rd(k) || basic_rd(k - 19)));
            chk("restart_done", k, 32'(tr_a[k].done), 32'((k == 19) || (k == 38)));
        end
        chk("restart_addr20", 20, 32'(tr_a[20].addr), 32'd0);

        // Reset in the middle of a frame
        run(30, 0, -1, -1, -1, -1, -1, 8, 9);
        chk("midrst_rd7", 7, 32'(tr_a[7].rd), 32'd1);
        chk_zero("midrst_a", 8, 1'b0);
        chk_zero("midrst_b", 8, 1'b1);
        for (int k = 10; k < 30; k++) begin
            chk("post_rst_rd",   k, 32'(tr_a[k].rd),   32'd0);
            chk("post_rst_gv",   k, 32'(tr_a[k].gv),   32'd0);
            chk("post_rst_busy", k, 32'(tr_a[k].busy), 32'd0);
            chk("post_rst_done", k, 32'(tr_a[k].done), 32'd0);
            chk("post_rst_done_b", k, 32'(tr_b[k].done), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
